// File: rtl/pe_row_drain.sv
// Drains one row of PE accumulators, requantizes by shift+saturate, streams them out.
// Optional PE_DRAIN_ROUND_EN: round half up before shifting instead of truncating.
module pe_row_drain #(
   parameter int NUM_PES                = 4,
   parameter int ACCUMULATOR_DATA_WIDTH = 16,
   parameter int OUT_DATA_WIDTH         = 8,
   parameter int SHIFT_WIDTH            = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [SHIFT_WIDTH-1:0]                    shift_amt,
   input  logic [NUM_PES*ACCUMULATOR_DATA_WIDTH-1:0] acc_in,
   output logic                                      acc_clear,
   output logic                                      busy,
   output logic [OUT_DATA_WIDTH-1:0]                 out_data,
   output logic [$clog2(NUM_PES)-1:0]                out_index,
   output logic                                      out_sat,
   output logic                                      out_last,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic                                      done
);

   localparam int ACC = ACCUMULATOR_DATA_WIDTH;
   localparam int OUT = OUT_DATA_WIDTH;
   localparam int IW  = $clog2(NUM_PES);

   localparam logic [IW-1:0] LAST = IW'(NUM_PES - 1);
   localparam logic signed [ACC:0] MAXV = (ACC+1)'((2 ** (OUT - 1)) - 1);
   localparam logic signed [ACC:0] MINV = ~MAXV;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM
   } state_t;

   state_t state;

   logic [ACC-1:0]         acc_buf [NUM_PES];
   logic [SHIFT_WIDTH-1:0] shift_r;
   logic [IW-1:0]          idx;
   logic [IW-1:0]          nxt;

   assign nxt       = idx + 1'b1;
   assign out_index = idx;
   assign out_last  = out_valid && (idx == LAST);
   assign busy      = (state != IDLE);

   // One extra bit of headroom so the rounding bias can never wrap.
   function automatic logic [OUT:0] requant(
      input logic [ACC-1:0]         x,
      input logic [SHIFT_WIDTH-1:0] s
   );
      logic signed [ACC:0] w;
      logic signed [ACC:0] y;
      logic signed [ACC:0] bias;
      int sh;
      sh = int'(s);
      if (sh > ACC) sh = ACC;
      w    = $signed({x[ACC-1], x});
      bias = '0;
`ifdef PE_DRAIN_ROUND_EN
      if (sh > 0) bias = $signed((ACC+1)'(1) << (sh - 1));
`endif
      w = w + bias;
      y = w >>> sh;
      if (y > MAXV) return {1'b1, MAXV[OUT-1:0]};
      if (y < MINV) return {1'b1, MINV[OUT-1:0]};
      return {1'b0, y[OUT-1:0]};
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         for (int i = 0; i < NUM_PES; i++) acc_buf[i] <= '0;
         shift_r   <= '0;
         idx       <= '0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_valid <= 1'b0;
         acc_clear <= 1'b0;
         done      <= 1'b0;
      end else begin
         acc_clear <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_PES; i++)
                     acc_buf[i] <= acc_in[i*ACC +: ACC];
                  shift_r   <= shift_amt;
                  idx       <= '0;
                  acc_clear <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               {out_sat, out_data} <= requant(acc_buf[0], shift_r);
               out_valid <= 1'b1;
               state     <= STREAM;
            end
            STREAM: begin
               if (out_ready) begin
                  if (idx == LAST) begin
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     idx <= nxt;
                     {out_sat, out_data} <= requant(acc_buf[nxt], shift_r);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_row_drain.sv
// Self-checking bench for pe_row_drain: vector table plus scoreboard queue.
// Build with +define+PE_DRAIN_ROUND_EN to check the rounding variant.
module tb_pe_row_drain;

   localparam int N = 4;
   localparam int A = 16;
   localparam int O = 8;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [S-1:0] shift_amt = '0;
   logic [N*A-1:0] acc_in = '0;
   logic         out_ready = 1'b0;
   logic         acc_clear, busy, out_sat, out_last, out_valid, done;
   logic [O-1:0] out_data;
   logic [1:0]   out_index;

   pe_row_drain dut (
      .clk(clk), .rst(rst), .start(start), .shift_amt(shift_amt),
      .acc_in(acc_in), .acc_clear(acc_clear), .busy(busy),
      .out_data(out_data), .out_index(out_index), .out_sat(out_sat),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic signed [31:0] act,
                      input logic signed [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [N-1:0][A-1:0] acc;
      logic [S-1:0]        sh;
      logic [N-1:0][O-1:0] d;
      logic [N-1:0]        s;
   } vec_t;

   typedef struct packed {
      logic [O-1:0] d;
      logic         s;
      logic [1:0]   idx;
      logic         last;
   } exp_t;

   exp_t sb[$];
   vec_t v[5];

   function automatic vec_t mk(input int a0, a1, a2, a3, input int sh,
                               input int d0, d1, d2, d3, input logic [3:0] s);
      vec_t r;
      r.acc[0] = 16'(a0); r.acc[1] = 16'(a1);
      r.acc[2] = 16'(a2); r.acc[3] = 16'(a3);
      r.sh = 4'(sh);
      r.d[0] = 8'(d0); r.d[1] = 8'(d1);
      r.d[2] = 8'(d2); r.d[3] = 8'(d3);
      r.s = s;
      return r;
   endfunction

   // mode 0: ready high; 1: ready 1,0,0,...; 2: ready high plus stray starts/acc changes
   task automatic run_drain(input vec_t vv, input int mode, input int abort_at);
      int   hs;
      int   clr;
      logic stalled;
      logic [O-1:0] hold_d;
      logic [1:0]   hold_i;
      exp_t e;
      hs = 0; clr = 0; stalled = 1'b0; hold_d = '0; hold_i = '0;
      acc_in = vv.acc; shift_amt = vv.sh; start = 1'b1;
      for (int i = 0; i < N; i++) begin
         e.d = vv.d[i]; e.s = vv.s[i]; e.idx = 2'(i); e.last = (i == N - 1);
         sb.push_back(e);
      end
      step;
      start = 1'b0; acc_in = ~vv.acc; shift_amt = ~vv.sh;
      chk("load_busy", 32'(busy), 1);
      chk("load_clear", 32'(acc_clear), 1);
      chk("load_valid", 32'(out_valid), 0);
      step;
      chk("first_valid", 32'(out_valid), 1);
      chk("clear_once", 32'(acc_clear), 0);
      for (int cyc = 0; cyc < 64; cyc++) begin
         if (stalled) begin
            chk("stall_data", $signed(out_data), $signed(hold_d));
            chk("stall_idx", 32'(out_index), 32'(hold_i));
         end
         if (acc_clear) clr++;
         chk("valid_held", 32'(out_valid), 1);
         if (!out_valid) break;
         out_ready = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
         if (mode == 2 && (cyc == 1 || cyc == 3)) begin
            start = 1'b1; acc_in = {$urandom, $urandom};
         end else begin
            start = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", sb.size(), 1);
               break;
            end
            e = sb.pop_front();
            chk("data", $signed(out_data), $signed(e.d));
            chk("sat", 32'(out_sat), 32'(e.s));
            chk("index", 32'(out_index), 32'(e.idx));
            chk("last", 32'(out_last), 32'(e.last));
            hs++;
            stalled = 1'b0;
            if (hs == abort_at) return;
            if (hs == N) break;
         end else begin
            stalled = out_valid; hold_d = out_data; hold_i = out_index;
         end
         step;
      end
      chk("hs_count", hs, N);
      step;
      start = 1'b0;
      chk("done", 32'(done), 1);
      chk("busy_end", 32'(busy), 0);
      chk("valid_end", 32'(out_valid), 0);
      chk("clear_stream", clr + 32'(acc_clear), 0);
      step;
      chk("done_pulse", 32'(done), 0);
      chk("no_restart", 32'(busy) + 32'(acc_clear), 0);
      out_ready = 1'b0;
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_data"}, 32'(out_data), 0);
      chk({tag, "_index"}, 32'(out_index), 0);
      chk({tag, "_sat"}, 32'(out_sat), 0);
      chk({tag, "_last"}, 32'(out_last), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_clear"}, 32'(acc_clear), 0);
   endtask

   initial begin
      v[0] = mk(100, -300, 32767, -32768, 2, 25, -75, 127, -128, 4'b1100);
      v[2] = mk(127, 128, -128, -129, 0, 127, 127, -128, -128, 4'b1010);
`ifdef PE_DRAIN_ROUND_EN
      v[1] = mk(102, -301, 6, -6, 2, 26, -75, 2, -1, 4'b0000);
      v[3] = mk(5, -5, 0, -1, 15, 0, 0, 0, 0, 4'b0000);
      v[4] = mk(1000, -1000, 2032, -2049, 4, 63, -62, 127, -128, 4'b0000);
`else
      v[1] = mk(102, -301, 6, -6, 2, 25, -76, 1, -2, 4'b0000);
      v[3] = mk(5, -5, 0, -1, 15, 0, -1, 0, -1, 4'b0000);
      v[4] = mk(1000, -1000, 2032, -2049, 4, 62, -63, 127, -128, 4'b1000);
`endif
      #1;
      chk_zero("reset");
      step;
      step;
      rst = 1'b1;
      step;

      for (int r = 0; r < 5; r++) run_drain(v[r], 0, -1);
      run_drain(v[0], 1, -1);
      run_drain(v[1], 1, -1);
      run_drain(v[2], 2, -1);

      run_drain(v[0], 0, 2);
      step;
      #2 rst = 1'b0;
      #1;
      chk_zero("abort");
      for (int i = 0; i < 3; i++) begin
         step;
         chk("abort_no_done", 32'(done), 0);
      end
      rst = 1'b1;
      sb.delete();
      step;
      run_drain(v[4], 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
